// File: rtl/acc_control_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator datapath: owns PC, IR, MBR
// and the memory request/acknowledge handshake, and issues one-cycle AC strobes.
module acc_control_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic [31:0]       ac_value,
  output logic [31:0]       operand,
  output logic              clear_enable,
  output logic              ac_load,
  output logic              ac_add,
  output logic              ac_sub,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_STORE, S_EXECUTE, S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [31:0]       ir_q, ir_d, operand_q, operand_d, mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              clear_q, clear_d, load_q, load_d, add_q, add_d, sub_q, sub_d;
  logic              halted_q, halted_d, illegal_q, illegal_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic [1:0]        skip_cond;
  logic              skip_take;
  logic [ADDR_W-1:0] exec_pc;

  assign opcode    = ir_q[31:28];
  assign ir_addr   = ir_q[ADDR_W-1:0];
  assign skip_cond = ir_q[ADDR_W-1:ADDR_W-2];

  always_comb begin
    case (skip_cond)
      2'b00:   skip_take = ac_value[31];
      2'b01:   skip_take = (ac_value == 32'd0);
      2'b10:   skip_take = !ac_value[31] && (ac_value != 32'd0);
      default: skip_take = 1'b0;
    endcase
  end

  always_comb begin
    exec_pc = pc_q;
    if (opcode == OP_JUMP)
      exec_pc = ir_addr;
    else if (opcode == OP_SKIP && skip_take)
      exec_pc = pc_q + ADDR_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    operand_d   = operand_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    clear_d     = 1'b0;
    load_d      = 1'b0;
    add_d       = 1'b0;
    sub_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d      = mem_rdata;
          pc_d      = pc_q + ADDR_W'(1);
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT: begin
            state_d    = S_OPERAND;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = ir_addr;
          end
          OP_STORE: begin
            // Store data is captured here and held for the whole write.
            state_d     = S_STORE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = ir_addr;
            mem_wdata_d = ac_value;
          end
          OP_HALT, OP_SKIP, OP_JUMP, OP_CLEAR: begin
            state_d = S_EXECUTE;
            clear_d = (opcode == OP_CLEAR);
          end
          default: begin
            state_d   = S_EXECUTE;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_OPERAND: begin
        if (mem_ack) begin
          operand_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_EXECUTE;
          load_d    = (opcode == OP_LOAD);
          add_d     = (opcode == OP_ADD);
          sub_d     = (opcode == OP_SUBT);
        end
      end
      S_STORE: begin
        if (mem_ack) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end
      S_EXECUTE: begin
        pc_d = exec_pc;
        if (opcode == OP_HALT) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = exec_pc;
        end
      end
      S_HALTED: begin
        halted_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_INIT;
      ir_q        <= '0;
      operand_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      clear_q     <= 1'b0;
      load_q      <= 1'b0;
      add_q       <= 1'b0;
      sub_q       <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      operand_q   <= operand_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      clear_q     <= clear_d;
      load_q      <= load_d;
      add_q       <= add_d;
      sub_q       <= sub_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign operand      = operand_q;
  assign clear_enable = clear_q;
  assign ac_load      = load_q;
  assign ac_add       = add_q;
  assign ac_sub       = sub_q;
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign halted       = halted_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_acc_control_sequencer.sv
// Directed bench for acc_control_sequencer: a wait-state memory model checks each
// access against an expected-access queue, and a monitor checks AC strobes likewise.
module tb_acc_control_sequencer;

  localparam int AW = 12;

  localparam logic [3:0] K_CLEAR = 4'b1000;
  localparam logic [3:0] K_LOAD  = 4'b0100;
  localparam logic [3:0] K_ADD   = 4'b0010;
  localparam logic [3:0] K_SUB   = 4'b0001;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          mem_ack = 1'b0;
  logic [31:0]   ac_value = 32'd0;
  logic [31:0]   operand;
  logic          clear_enable, ac_load, ac_add, ac_sub;
  logic [AW-1:0] pc;
  logic [31:0]   ir;
  logic          halted, illegal_op;

  acc_control_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ac_value(ac_value),
    .operand(operand), .clear_enable(clear_enable), .ac_load(ac_load),
    .ac_add(ac_add), .ac_sub(ac_sub), .pc(pc), .ir(ir),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic we; logic [31:0] wdata; } acc_t;
  typedef struct { logic [3:0] kind; logic [31:0] opnd; } stb_t;

  acc_t        aq[$];
  stb_t        sq[$];
  logic [31:0] mem [0:(1<<AW)-1];
  int          ntests = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          first_req_cyc = -1;
  int          last_strobe_cyc = -1;
  int          wait_states = 0;
  int          wcnt = 0;
  int          n_acks = 0;
  logic        in_txn = 1'b0;
  acc_t        cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: acks after wait_states idle request cycles, checks held request.
  always @(negedge clk) begin
    acc_t e;
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
    if (!reset_n || !mem_req) begin
      if (reset_n && in_txn) check("req_held", {31'd0, mem_req}, 32'd1);
      in_txn = 1'b0;
      wcnt = 0;
    end else begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (!in_txn) begin
        in_txn = 1'b1;
        cap.addr = mem_addr; cap.we = mem_we; cap.wdata = mem_wdata;
      end else begin
        check("addr_stable", mem_addr, cap.addr);
        check("we_stable", {31'd0, mem_we}, {31'd0, cap.we});
        check("wdata_stable", mem_wdata, cap.wdata);
      end
      if (wcnt >= wait_states) begin
        mem_ack = 1'b1;
        n_acks++;
        in_txn = 1'b0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem[mem_addr];
        if (aq.size() == 0) begin
          check("unexpected_access", {19'd0, mem_we, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = aq.pop_front();
          check("acc_addr", mem_addr, e.addr);
          check("acc_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) check("acc_wdata", mem_wdata, e.wdata);
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    logic [3:0] k;
    stb_t e;
    k = {clear_enable, ac_load, ac_add, ac_sub};
    if (reset_n && k != 4'd0) begin
      check("strobe_onehot", {31'd0, $onehot(k)}, 32'd1);
      last_strobe_cyc = cyc;
      if (sq.size() == 0) begin
        check("unexpected_strobe", {28'd0, k}, 32'd0);
      end else begin
        e = sq.pop_front();
        check("strobe_kind", {28'd0, k}, {28'd0, e.kind});
        if (e.kind != K_CLEAR) check("strobe_operand", operand, e.opnd);
      end
    end
  end

  task automatic exp_acc(input logic [AW-1:0] a, input logic we, input logic [31:0] d);
    acc_t e;
    e.addr = a; e.we = we; e.wdata = d;
    aq.push_back(e);
  endtask

  task automatic exp_stb(input logic [3:0] k, input logic [31:0] d);
    stb_t e;
    e.kind = k; e.opnd = d;
    sq.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    run = 1'b0;
    aq.delete();
    sq.delete();
    n_acks = 0;
    first_req_cyc = -1;
    last_strobe_cyc = -1;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'd0;
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  task automatic start();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_acc_q_empty"}, aq.size(), 32'd0);
    check({tag, "_stb_q_empty"}, sq.size(), 32'd0);
  endtask

  logic [1:0]  sk_cond [7] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
  logic [31:0] sk_ac   [7] = '{32'd0, 32'd1, 32'h8000_0000, 32'd0, 32'd5, 32'h8000_0000, 32'd0};
  logic        sk_take [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int n;
    int reqs;

    // Reset, idle with run low, then start.
    do_reset();
    mem[0] = 32'h7000_0000;
    exp_acc(12'h000, 1'b0, 32'd0);
    release_reset();
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check("idle_no_req", reqs, 32'd0);
    check("rst_pc", {20'd0, pc}, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_operand", operand, 32'd0);
    check("rst_strobes", {28'd0, clear_enable, ac_load, ac_add, ac_sub}, 32'd0);
    check("rst_flags", {30'd0, halted, illegal_op}, 32'd0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("run_req", {31'd0, mem_req}, 32'd1);
    check("run_addr", {20'd0, mem_addr}, 32'd0);
    check("run_we", {31'd0, mem_we}, 32'd0);
    wait_halt("t1");

    // Clear, zero wait states: strobe two cycles after fetch start.
    do_reset();
    wait_states = 0;
    mem[0] = 32'hA000_0000;
    mem[1] = 32'h7000_0000;
    exp_acc(12'h000, 1'b0, 32'd0);
    exp_stb(K_CLEAR, 32'd0);
    exp_acc(12'h001, 1'b0, 32'd0);
    release_reset();
    start();
    wait_halt("t2");
    check("clear_latency", last_strobe_cyc - first_req_cyc, 32'd2);
    check("t2_pc", {20'd0, pc}, 32'd2);
    check("t2_acks", n_acks, 32'd2);
    check("t2_illegal", {31'd0, illegal_op}, 32'd0);

    // Load with 3 wait states per access.
    do_reset();
    wait_states = 3;
    mem[0] = 32'h1000_0005;
    mem[1] = 32'h7000_0000;
    mem[5] = 32'h1234_5678;
    exp_acc(12'h000, 1'b0, 32'd0);
    exp_acc(12'h005, 1'b0, 32'd0);
    exp_stb(K_LOAD, 32'h1234_5678);
    exp_acc(12'h001, 1'b0, 32'd0);
    release_reset();
    start();
    wait_halt("t3");
    check("t3_operand_held", operand, 32'h1234_5678);
    check("t3_pc", {20'd0, pc}, 32'd2);

    // Store: data captured on entry, later AC changes must not leak into the write.
    do_reset();
    wait_states = 1;
    ac_value = 32'hDEAD_BEEF;
    mem[0] = 32'hA000_0000;
    mem[1] = 32'h2000_0007;
    mem[2] = 32'h7000_0000;
    exp_acc(12'h000, 1'b0, 32'd0);
    exp_stb(K_CLEAR, 32'd0);
    exp_acc(12'h001, 1'b0, 32'd0);
    exp_acc(12'h007, 1'b1, 32'hDEAD_BEEF);
    exp_acc(12'h002, 1'b0, 32'd0);
    release_reset();
    start();
    n = 0;
    while (!(mem_req && mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    ac_value = 32'd0;
    wait_halt("t4");
    check("t4_mem7", mem[7], 32'hDEAD_BEEF);

    // Add then Subt.
    do_reset();
    wait_states = 0;
    mem[0] = 32'h3000_0010;
    mem[1] = 32'h4000_0011;
    mem[2] = 32'h7000_0000;
    mem[16] = 32'd5;
    mem[17] = 32'd7;
    exp_acc(12'h000, 1'b0, 32'd0);
    exp_acc(12'h010, 1'b0, 32'd0);
    exp_stb(K_ADD, 32'd5);
    exp_acc(12'h001, 1'b0, 32'd0);
    exp_acc(12'h011, 1'b0, 32'd0);
    exp_stb(K_SUB, 32'd7);
    exp_acc(12'h002, 1'b0, 32'd0);
    release_reset();
    start();
    wait_halt("t_addsub");

    // Skipcond over all conditions; a skipped Clear must not strobe.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      wait_states = i % 2;
      ac_value = sk_ac[i];
      mem[0] = 32'h8000_0000 | ({30'd0, sk_cond[i]} << 10);
      mem[1] = 32'hA000_0000;
      mem[2] = 32'h7000_0000;
      exp_acc(12'h000, 1'b0, 32'd0);
      if (!sk_take[i]) begin
        exp_acc(12'h001, 1'b0, 32'd0);
        exp_stb(K_CLEAR, 32'd0);
      end
      exp_acc(12'h002, 1'b0, 32'd0);
      release_reset();
      start();
      wait_halt("skip");
      check("skip_pc", {20'd0, pc}, 32'd3);
    end

    // Jump to the top of memory; PC wraps after the fetch there.
    do_reset();
    wait_states = 0;
    mem[0] = 32'h9000_0FFF;
    mem[12'hFFF] = 32'h7000_0000;
    exp_acc(12'h000, 1'b0, 32'd0);
    exp_acc(12'hFFF, 1'b0, 32'd0);
    release_reset();
    start();
    wait_halt("jump");
    check("jump_pc_wrap", {20'd0, pc}, 32'd0);

    // Illegal opcode is a sticky NOP; Halt stops all requests and ignores run.
    do_reset();
    wait_states = 2;
    mem[0] = 32'hF000_0000;
    mem[1] = 32'h7000_0000;
    exp_acc(12'h000, 1'b0, 32'd0);
    exp_acc(12'h001, 1'b0, 32'd0);
    release_reset();
    start();
    wait_halt("illegal");
    check("illegal_set", {31'd0, illegal_op}, 32'd1);
    run = 1'b1;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    run = 1'b0;
    check("halt_no_req", reqs, 32'd0);
    check("halt_acks", n_acks, 32'd2);
    check("illegal_sticky", {31'd0, illegal_op}, 32'd1);
    check("halted_held", {31'd0, halted}, 32'd1);

    // Reset in the middle of a waited fetch.
    do_reset();
    #1;
    check("rst_clears_illegal", {31'd0, illegal_op}, 32'd0);
    check("rst_clears_halted", {31'd0, halted}, 32'd0);
    wait_states = 5;
    mem[0] = 32'hA000_0000;
    release_reset();
    start();
    @(negedge clk);
    check("midfetch_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midfetch_rst_req", {31'd0, mem_req}, 32'd0);
    check("midfetch_rst_pc", {20'd0, pc}, 32'd0);
    check("midfetch_rst_acks", n_acks, 32'd0);
    aq.delete();
    sq.delete();
    release_reset();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
